// File: rtl/alu_seq.sv
// alu_seq: control sequencer for a 4-bit-core ALU performing one 8-bit op.
// It loads OP1/OP2 through the input shifter, then runs the low nibble pass
// and the high nibble pass, drives the result onto the external bus, and
// assembles the Z80 flag byte {S,Z,Y,H,X,PV,N,C}.
// Every control output is registered. Each output value is decoded from the
// next state, so it is valid for the whole cycle spent in that state.
module alu_seq (
   input  logic       clk,
   input  logic       nreset,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] op,
   input  logic       cf_in,
   output logic       ready,
   output logic [1:0] db_sel,
   output logic [2:0] bus_sel,
   output logic       alu_oe,
   output logic       alu_op1_sel_bus,
   output logic       alu_op2_sel_bus,
   output logic       alu_sel_op2_neg,
   output logic       alu_sel_op2_high,
   output logic       alu_op_low,
   output logic       alu_core_cf_in,
   output logic       alu_core_R,
   output logic       alu_core_S,
   output logic       alu_core_V,
   output logic       alu_parity_in,
   input  logic       alu_core_cf_out,
   input  logic       alu_parity_out,
   input  logic       alu_zero,
   input  logic       alu_sf_out,
   input  logic       alu_yf_out,
   input  logic       alu_xf_out,
   input  logic       alu_vf_out,
   output logic [7:0] flags,
   output logic       flags_we,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE, S_LDA, S_LDB, S_LOW, S_HIGH, S_RES
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP
   } op_t;

   typedef enum logic [2:0] {
      BUS_HIGHZ, BUS_OP1, BUS_OP2, BUS_RES, BUS_SHIFT, BUS_BS
   } bus_t;

   typedef enum logic [1:0] {
      DB_NONE, DB_OPA, DB_OPB
   } db_t;

   // sequencer state and captured request
   state_t     state_q, state_d;
   op_t        op_q, op_d;
   logic       cf_q, cf_d;

   // partial results carried from the low pass into the high pass
   logic       hf_q, hf_d;
   logic       pf_q, pf_d;
   logic       zl_q, zl_d;

   logic [7:0] flags_q, flags_d;

   // registered control outputs
   logic       ready_q, ready_d;
   db_t        db_sel_q, db_sel_d;
   bus_t       bus_sel_q, bus_sel_d;
   logic       alu_oe_q, alu_oe_d;
   logic       op1_sel_q, op1_sel_d;
   logic       op2_sel_q, op2_sel_d;
   logic       neg_q, neg_d;
   logic       high_q, high_d;
   logic       op_low_q, op_low_d;
   logic       core_cf_q, core_cf_d;
   logic [2:0] rsv_q, rsv_d;
   logic       parity_in_q, parity_in_d;
   logic       flags_we_q, flags_we_d;
   logic       done_q, done_d;

   // op decode
   logic       sub_op;
   logic       logic_op;
   logic       cin;
   logic [2:0] rsv_op;

   // next state; request is captured on acceptance, abort overrides any advance
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cf_d    = cf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LDA;
               op_d    = op_t'(op);
               cf_d    = cf_in;
            end
         end
         S_LDA:   state_d = S_LDB;
         S_LDB:   state_d = S_LOW;
         S_LOW:   state_d = S_HIGH;
         S_HIGH:  state_d = S_RES;
         S_RES:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
   end

   // decode the captured op into core function, operand negation and carry-in
   always_comb begin
      sub_op   = 1'b0;
      logic_op = 1'b0;
      cin      = 1'b0;
      rsv_op   = 3'b000;
      case (op_d)
         OP_ADD: cin = 1'b0;
         OP_ADC: cin = cf_d;
         OP_SUB: begin
            sub_op = 1'b1;
            cin    = 1'b1;
         end
         OP_SBC: begin
            sub_op = 1'b1;
            cin    = ~cf_d;
         end
         OP_AND: begin
            logic_op = 1'b1;
            rsv_op   = 3'b001;
         end
         OP_XOR: begin
            logic_op = 1'b1;
            rsv_op   = 3'b010;
         end
         OP_OR: begin
            logic_op = 1'b1;
            rsv_op   = 3'b011;
         end
         OP_CP: begin
            sub_op = 1'b1;
            cin    = 1'b1;
         end
         default: cin = 1'b0;
      endcase
   end

   // capture low-pass carry/parity/zero, then assemble flags at end of the high pass
   always_comb begin
      hf_d    = hf_q;
      pf_d    = pf_q;
      zl_d    = zl_q;
      flags_d = flags_q;
      if ((state_q == S_LOW) && (state_d == S_HIGH)) begin
         hf_d = alu_core_cf_out;
         pf_d = alu_parity_out;
         zl_d = alu_zero;
      end
      // flags are committed only when the op really proceeds to RES
      if ((state_q == S_HIGH) && (state_d == S_RES)) begin
         flags_d[7] = alu_sf_out;
         flags_d[6] = zl_q & alu_zero;
         flags_d[5] = alu_yf_out;
         flags_d[4] = logic_op ? (op_q == OP_AND) : (hf_q ^ sub_op);
         flags_d[3] = alu_xf_out;
         flags_d[2] = logic_op ? alu_parity_out : alu_vf_out;
         flags_d[1] = sub_op;
         flags_d[0] = logic_op ? 1'b0 : (alu_core_cf_out ^ sub_op);
      end
   end

   // control outputs for the state about to be entered
   always_comb begin
      ready_d     = 1'b0;
      db_sel_d    = DB_NONE;
      bus_sel_d   = BUS_HIGHZ;
      alu_oe_d    = 1'b0;
      op1_sel_d   = 1'b0;
      op2_sel_d   = 1'b0;
      neg_d       = 1'b0;
      high_d      = 1'b0;
      op_low_d    = 1'b0;
      core_cf_d   = 1'b0;
      rsv_d       = 3'b000;
      parity_in_d = 1'b0;
      flags_we_d  = 1'b0;
      done_d      = 1'b0;
      case (state_d)
         S_IDLE: ready_d = 1'b1;
         S_LDA: begin
            db_sel_d  = DB_OPA;
            bus_sel_d = BUS_SHIFT;
            op1_sel_d = 1'b1;
         end
         S_LDB: begin
            db_sel_d  = DB_OPB;
            bus_sel_d = BUS_SHIFT;
            op2_sel_d = 1'b1;
         end
         S_LOW: begin
            op_low_d    = 1'b1;
            neg_d       = sub_op;
            core_cf_d   = cin;
            rsv_d       = rsv_op;
            parity_in_d = 1'b0;
         end
         S_HIGH: begin
            high_d      = 1'b1;
            neg_d       = sub_op;
            core_cf_d   = hf_d;
            rsv_d       = rsv_op;
            parity_in_d = pf_d;
         end
         S_RES: begin
            bus_sel_d  = BUS_RES;
            alu_oe_d   = (op_d != OP_CP);
            flags_we_d = 1'b1;
            done_d     = 1'b1;
         end
         default: ready_d = 1'b1;
      endcase
   end

   // all sequencer state, datapath flag registers and control outputs
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ADD;
         cf_q        <= 1'b0;
         hf_q        <= 1'b0;
         pf_q        <= 1'b0;
         zl_q        <= 1'b0;
         flags_q     <= '0;
         ready_q     <= 1'b1;
         db_sel_q    <= DB_NONE;
         bus_sel_q   <= BUS_HIGHZ;
         alu_oe_q    <= 1'b0;
         op1_sel_q   <= 1'b0;
         op2_sel_q   <= 1'b0;
         neg_q       <= 1'b0;
         high_q      <= 1'b0;
         op_low_q    <= 1'b0;
         core_cf_q   <= 1'b0;
         rsv_q       <= '0;
         parity_in_q <= 1'b0;
         flags_we_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cf_q        <= cf_d;
         hf_q        <= hf_d;
         pf_q        <= pf_d;
         zl_q        <= zl_d;
         flags_q     <= flags_d;
         ready_q     <= ready_d;
         db_sel_q    <= db_sel_d;
         bus_sel_q   <= bus_sel_d;
         alu_oe_q    <= alu_oe_d;
         op1_sel_q   <= op1_sel_d;
         op2_sel_q   <= op2_sel_d;
         neg_q       <= neg_d;
         high_q      <= high_d;
         op_low_q    <= op_low_d;
         core_cf_q   <= core_cf_d;
         rsv_q       <= rsv_d;
         parity_in_q <= parity_in_d;
         flags_we_q  <= flags_we_d;
         done_q      <= done_d;
      end
   end

   assign ready            = ready_q;
   assign db_sel           = db_sel_q;
   assign bus_sel          = bus_sel_q;
   assign alu_oe           = alu_oe_q;
   assign alu_op1_sel_bus  = op1_sel_q;
   assign alu_op2_sel_bus  = op2_sel_q;
   assign alu_sel_op2_neg  = neg_q;
   assign alu_sel_op2_high = high_q;
   assign alu_op_low       = op_low_q;
   assign alu_core_cf_in   = core_cf_q;
   assign alu_core_R       = rsv_q[2];
   assign alu_core_S       = rsv_q[1];
   assign alu_core_V       = rsv_q[0];
   assign alu_parity_in    = parity_in_q;
   assign flags            = flags_q;
   assign flags_we         = flags_we_q;
   assign done             = done_q;

endmodule
